// File: rtl/gb_cluster_acc_if.sv
// gb_cluster_acc_if
//   Bus bundle between the controller/DMA (master) and the global-buffer
//   cluster (slave).
//   iact / wght : read request + address in, registered data + valid out,
//                 write enable + address + data in.
//   psum        : local read port, write port with accumulate select,
//                 and the inter-cluster burst port (base address in,
//                 packed X_dim-lane word, completion pulse and busy out).
interface gb_cluster_acc_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int X_dim         = 3
) ();

  logic                             read_req_iact;
  logic [ADDR_BITWIDTH-1:0]         r_addr_iact;
  logic [DATA_BITWIDTH-1:0]         r_data_iact;
  logic                             r_valid_iact;
  logic                             write_en_iact;
  logic [ADDR_BITWIDTH-1:0]         w_addr_iact;
  logic [DATA_BITWIDTH-1:0]         w_data_iact;

  logic                             read_req_wght;
  logic [ADDR_BITWIDTH-1:0]         r_addr_wght;
  logic [DATA_BITWIDTH-1:0]         r_data_wght;
  logic                             r_valid_wght;
  logic                             write_en_wght;
  logic [ADDR_BITWIDTH-1:0]         w_addr_wght;
  logic [DATA_BITWIDTH-1:0]         w_data_wght;

  logic                             read_req_psum;
  logic [ADDR_BITWIDTH-1:0]         r_addr_psum;
  logic [DATA_BITWIDTH-1:0]         r_data_psum;
  logic                             r_valid_psum;
  logic                             write_en_psum;
  logic                             acc_en_psum;
  logic [ADDR_BITWIDTH-1:0]         w_addr_psum;
  logic [DATA_BITWIDTH-1:0]         w_data_psum;

  logic                             read_req_psum_inter;
  logic [ADDR_BITWIDTH-1:0]         r_addr_psum_inter;
  logic [DATA_BITWIDTH*X_dim-1:0]   r_data_psum_inter;
  logic                             read_en_psum_inter;
  logic                             inter_busy;

  modport master (
    output read_req_iact, r_addr_iact, write_en_iact, w_addr_iact, w_data_iact,
    output read_req_wght, r_addr_wght, write_en_wght, w_addr_wght, w_data_wght,
    output read_req_psum, r_addr_psum, write_en_psum, acc_en_psum, w_addr_psum, w_data_psum,
    output read_req_psum_inter, r_addr_psum_inter,
    input  r_data_iact, r_valid_iact, r_data_wght, r_valid_wght,
    input  r_data_psum, r_valid_psum, r_data_psum_inter, read_en_psum_inter, inter_busy
  );

  modport slave (
    input  read_req_iact, r_addr_iact, write_en_iact, w_addr_iact, w_data_iact,
    input  read_req_wght, r_addr_wght, write_en_wght, w_addr_wght, w_data_wght,
    input  read_req_psum, r_addr_psum, write_en_psum, acc_en_psum, w_addr_psum, w_data_psum,
    input  read_req_psum_inter, r_addr_psum_inter,
    output r_data_iact, r_valid_iact, r_data_wght, r_valid_wght,
    output r_data_psum, r_valid_psum, r_data_psum_inter, read_en_psum_inter, inter_busy
  );

endinterface

// File: rtl/gb_cluster_acc.sv
// gb_cluster_acc
//   Global-buffer cluster: owns the iact, wght and psum SRAMs.
//   - iact/wght: 1-cycle registered reads, old data on same-cycle read/write.
//   - psum: 2-stage write pipeline (stage 0 fetches old value, stage 1
//     commits) supporting plain writes and signed accumulate (saturating or
//     wrapping). Reads forward from both stages so a read sees every write
//     issued in earlier cycles.
//   - Burst engine gathers X_dim consecutive psums into one packed word;
//     the local psum read port has priority and stalls the burst.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : gb_cluster_acc_if slave modport (all data/handshake signals)
module gb_cluster_acc #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int X_dim         = 3,
  parameter bit SATURATE      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  gb_cluster_acc_if.slave bus
);

  localparam int DW    = DATA_BITWIDTH;
  localparam int AW    = ADDR_BITWIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = DW * X_dim;
  localparam int KW    = (X_dim > 1) ? $clog2(X_dim) : 1;

  localparam logic [KW-1:0] K_LAST   = KW'(X_dim - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Signed add of two psum words; clamps on overflow when SATURATE is set,
  // otherwise wraps modulo 2**DW.
  function automatic logic [DW-1:0] psum_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (SATURATE && (sum[DW] != sum[DW-1])) begin
      res = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      res = sum[DW-1:0];
    end
    return res;
  endfunction

  // Storage (not affected by reset)
  logic [DW-1:0] mem_iact [DEPTH];
  logic [DW-1:0] mem_wght [DEPTH];
  logic [DW-1:0] mem_psum [DEPTH];

  // Registered outputs
  logic [DW-1:0] r_data_iact_q, r_data_wght_q, r_data_psum_q;
  logic          r_valid_iact_q, r_valid_wght_q, r_valid_psum_q;
  logic [LW-1:0] r_data_inter_q;
  logic          read_en_inter_q;
  logic          busy_q;

  // psum write pipeline
  logic          s0_valid_q, s0_acc_q, s1_valid_q;
  logic [AW-1:0] s0_addr_q, s1_addr_q;
  logic [DW-1:0] s0_data_q, s1_data_q;
  logic [DW-1:0] s0_old_s, s0_result_s;

  // Coherent read values
  logic [DW-1:0] local_rd_s, burst_rd_s;

  // Burst engine
  state_e        state_q, state_d;
  logic [AW-1:0] burst_addr_q;
  logic [KW-1:0] k_q;
  logic [LW-1:0] lanes_q, next_lanes_s;
  logic          start_s, issue_s, last_s;

  // iact write port
  always_ff @(posedge clk) begin
    if (bus.write_en_iact) mem_iact[bus.w_addr_iact] <= bus.w_data_iact;
  end

  // wght write port
  always_ff @(posedge clk) begin
    if (bus.write_en_wght) mem_wght[bus.w_addr_wght] <= bus.w_data_wght;
  end

  // iact/wght registered read ports; data holds when no read is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_iact_q  <= {DW{1'b0}};
      r_valid_iact_q <= 1'b0;
      r_data_wght_q  <= {DW{1'b0}};
      r_valid_wght_q <= 1'b0;
    end else begin
      r_valid_iact_q <= bus.read_req_iact;
      r_valid_wght_q <= bus.read_req_wght;
      if (bus.read_req_iact) r_data_iact_q <= mem_iact[bus.r_addr_iact];
      if (bus.read_req_wght) r_data_wght_q <= mem_wght[bus.r_addr_wght];
    end
  end

  // Stage 0 old value (stage 1 forwarded for back-to-back same-address writes) and its update
  always_comb begin
    if (s1_valid_q && (s1_addr_q == s0_addr_q)) begin
      s0_old_s = s1_data_q;
    end else begin
      s0_old_s = mem_psum[s0_addr_q];
    end
    if (s0_acc_q) begin
      s0_result_s = psum_add(s0_old_s, s0_data_q);
    end else begin
      s0_result_s = s0_data_q;
    end
  end

  // psum write pipeline registers: stage 0 captures the request, stage 1 holds the value to commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid_q <= 1'b0;
      s0_acc_q   <= 1'b0;
      s0_addr_q  <= {AW{1'b0}};
      s0_data_q  <= {DW{1'b0}};
      s1_valid_q <= 1'b0;
      s1_addr_q  <= {AW{1'b0}};
      s1_data_q  <= {DW{1'b0}};
    end else begin
      s0_valid_q <= bus.write_en_psum;
      if (bus.write_en_psum) begin
        s0_addr_q <= bus.w_addr_psum;
        s0_data_q <= bus.w_data_psum;
        s0_acc_q  <= bus.acc_en_psum;
      end
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_addr_q <= s0_addr_q;
        s1_data_q <= s0_result_s;
      end
    end
  end

  // psum commit from stage 1
  always_ff @(posedge clk) begin
    if (s1_valid_q) mem_psum[s1_addr_q] <= s1_data_q;
  end

  // Coherent psum reads: stage 0 is the newest pending write, then stage 1, then the array
  always_comb begin
    if (s0_valid_q && (s0_addr_q == bus.r_addr_psum)) begin
      local_rd_s = s0_result_s;
    end else if (s1_valid_q && (s1_addr_q == bus.r_addr_psum)) begin
      local_rd_s = s1_data_q;
    end else begin
      local_rd_s = mem_psum[bus.r_addr_psum];
    end
    if (s0_valid_q && (s0_addr_q == burst_addr_q)) begin
      burst_rd_s = s0_result_s;
    end else if (s1_valid_q && (s1_addr_q == burst_addr_q)) begin
      burst_rd_s = s1_data_q;
    end else begin
      burst_rd_s = mem_psum[burst_addr_q];
    end
  end

  // Local psum registered read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_psum_q  <= {DW{1'b0}};
      r_valid_psum_q <= 1'b0;
    end else begin
      r_valid_psum_q <= bus.read_req_psum;
      if (bus.read_req_psum) r_data_psum_q <= local_rd_s;
    end
  end

  // Burst FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst FSM next state; a local read stalls the burst for that cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.read_req_psum_inter) state_d = ST_BURST;
        else                         state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (!bus.read_req_psum && (k_q == K_LAST)) state_d = ST_DONE;
        else                                       state_d = ST_BURST;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Burst FSM control strobes
  always_comb begin
    start_s = 1'b0;
    issue_s = 1'b0;
    last_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.read_req_psum_inter) start_s = 1'b1;
        else                         start_s = 1'b0;
      end
      ST_BURST: begin
        if (!bus.read_req_psum) begin
          issue_s = 1'b1;
          last_s  = (k_q == K_LAST);
        end else begin
          issue_s = 1'b0;
          last_s  = 1'b0;
        end
      end
      ST_DONE: begin
        start_s = 1'b0;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Lane staging: the lane addressed by k takes this cycle's burst read
  always_comb begin
    next_lanes_s = lanes_q;
    for (int j = 0; j < X_dim; j++) begin
      if (k_q == KW'(j)) next_lanes_s[j*DW +: DW] = burst_rd_s;
      else               next_lanes_s[j*DW +: DW] = lanes_q[j*DW +: DW];
    end
  end

  // Burst datapath: address/lane counters, lane staging, packed output and completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_addr_q    <= {AW{1'b0}};
      k_q             <= {KW{1'b0}};
      lanes_q         <= {LW{1'b0}};
      r_data_inter_q  <= {LW{1'b0}};
      read_en_inter_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      if (start_s) begin
        burst_addr_q <= bus.r_addr_psum_inter;
        k_q          <= {KW{1'b0}};
      end else if (issue_s) begin
        burst_addr_q <= burst_addr_q + ADDR_ONE;
        k_q          <= k_q + K_ONE;
        lanes_q      <= next_lanes_s;
      end
      if (start_s)     busy_q <= 1'b1;
      else if (last_s) busy_q <= 1'b0;
      read_en_inter_q <= last_s;
      // Output word only changes when a burst completes
      if (last_s) r_data_inter_q <= next_lanes_s;
    end
  end

  assign bus.r_data_iact        = r_data_iact_q;
  assign bus.r_valid_iact       = r_valid_iact_q;
  assign bus.r_data_wght        = r_data_wght_q;
  assign bus.r_valid_wght       = r_valid_wght_q;
  assign bus.r_data_psum        = r_data_psum_q;
  assign bus.r_valid_psum       = r_valid_psum_q;
  assign bus.r_data_psum_inter  = r_data_inter_q;
  assign bus.read_en_psum_inter = read_en_inter_q;
  assign bus.inter_busy         = busy_q;

endmodule

// File: tb/tb_gb_cluster_acc.sv
// tb_gb_cluster_acc
//   Directed bench for gb_cluster_acc. Two instances: saturating (main) and
//   wrapping (used for the accumulate-overflow cases). Expected read results
//   are pushed to a scoreboard with the cycle they are due and checked when
//   that cycle is sampled (negative clock edge).
module tb_gb_cluster_acc;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int XD = 3;

  typedef struct {
    int          port;
    int          due;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc_n;
  exp_t sb[$];

  logic [15:0] m_iact [int];
  logic [15:0] m_wght [int];
  logic [15:0] m_psum [int];
  logic [15:0] m_psumw [int];

  gb_cluster_acc_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD)) bus ();
  gb_cluster_acc_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD)) busw ();

  gb_cluster_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  gb_cluster_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .bus(busw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference accumulate using plain integer arithmetic.
  function automatic logic [15:0] model_acc(input logic [15:0] a, input logic [15:0] b, input bit sat);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (sat && s > 32767) s = 32767;
    else if (sat && s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next sampling point and check every output port against the scoreboard.
  task automatic cyc();
    logic        v;
    logic [63:0] d;
    int          idx;
    string       nm;
    @(negedge clk);
    cyc_n++;
    for (int p = 0; p < 5; p++) begin
      case (p)
        0: begin v = bus.r_valid_iact;       d = 64'(bus.r_data_iact);       nm = "iact";      end
        1: begin v = bus.r_valid_wght;       d = 64'(bus.r_data_wght);       nm = "wght";      end
        2: begin v = bus.r_valid_psum;       d = 64'(bus.r_data_psum);       nm = "psum";      end
        3: begin v = bus.read_en_psum_inter; d = 64'(bus.r_data_psum_inter); nm = "inter";     end
        default: begin v = busw.r_valid_psum; d = 64'(busw.r_data_psum);     nm = "psum_wrap"; end
      endcase
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].port == p && sb[i].due == cyc_n) idx = i;
      if (idx >= 0) begin
        chk({nm, "_valid"}, 64'(v), 64'd1);
        chk({nm, "_data"}, d, sb[idx].data);
        sb.delete(idx);
      end else begin
        chk({nm, "_idle"}, 64'(v), 64'd0);
      end
    end
  endtask

  task automatic clear_all();
    bus.read_req_iact = 1'b0; bus.r_addr_iact = '0; bus.write_en_iact = 1'b0;
    bus.w_addr_iact = '0; bus.w_data_iact = '0;
    bus.read_req_wght = 1'b0; bus.r_addr_wght = '0; bus.write_en_wght = 1'b0;
    bus.w_addr_wght = '0; bus.w_data_wght = '0;
    bus.read_req_psum = 1'b0; bus.r_addr_psum = '0; bus.write_en_psum = 1'b0;
    bus.acc_en_psum = 1'b0; bus.w_addr_psum = '0; bus.w_data_psum = '0;
    bus.read_req_psum_inter = 1'b0; bus.r_addr_psum_inter = '0;
    busw.read_req_iact = 1'b0; busw.r_addr_iact = '0; busw.write_en_iact = 1'b0;
    busw.w_addr_iact = '0; busw.w_data_iact = '0;
    busw.read_req_wght = 1'b0; busw.r_addr_wght = '0; busw.write_en_wght = 1'b0;
    busw.w_addr_wght = '0; busw.w_data_wght = '0;
    busw.read_req_psum = 1'b0; busw.r_addr_psum = '0; busw.write_en_psum = 1'b0;
    busw.acc_en_psum = 1'b0; busw.w_addr_psum = '0; busw.w_data_psum = '0;
    busw.read_req_psum_inter = 1'b0; busw.r_addr_psum_inter = '0;
  endtask

  task automatic wr_iact(input int a, input logic [15:0] d);
    bus.write_en_iact = 1'b1; bus.w_addr_iact = AW'(a); bus.w_data_iact = d;
    m_iact[a] = d;
    cyc();
    bus.write_en_iact = 1'b0;
  endtask

  task automatic rd_iact(input int a);
    bus.read_req_iact = 1'b1; bus.r_addr_iact = AW'(a);
    sb.push_back('{0, cyc_n + 1, 64'(m_iact[a])});
    cyc();
    bus.read_req_iact = 1'b0;
  endtask

  task automatic wr_wght(input int a, input logic [15:0] d);
    bus.write_en_wght = 1'b1; bus.w_addr_wght = AW'(a); bus.w_data_wght = d;
    m_wght[a] = d;
    cyc();
    bus.write_en_wght = 1'b0;
  endtask

  task automatic rd_wght(input int a);
    bus.read_req_wght = 1'b1; bus.r_addr_wght = AW'(a);
    sb.push_back('{1, cyc_n + 1, 64'(m_wght[a])});
    cyc();
    bus.read_req_wght = 1'b0;
  endtask

  task automatic wr_psum(input int a, input logic [15:0] d, input bit acc);
    bus.write_en_psum = 1'b1; bus.acc_en_psum = acc; bus.w_addr_psum = AW'(a); bus.w_data_psum = d;
    m_psum[a] = acc ? model_acc(m_psum[a], d, 1'b1) : d;
    cyc();
    bus.write_en_psum = 1'b0; bus.acc_en_psum = 1'b0;
  endtask

  task automatic rd_psum(input int a);
    bus.read_req_psum = 1'b1; bus.r_addr_psum = AW'(a);
    sb.push_back('{2, cyc_n + 1, 64'(m_psum[a])});
    cyc();
    bus.read_req_psum = 1'b0;
  endtask

  // Same psum write on both the saturating and the wrapping instance.
  task automatic wr_both(input int a, input logic [15:0] d, input bit acc);
    bus.write_en_psum = 1'b1;  bus.acc_en_psum = acc;  bus.w_addr_psum = AW'(a);  bus.w_data_psum = d;
    busw.write_en_psum = 1'b1; busw.acc_en_psum = acc; busw.w_addr_psum = AW'(a); busw.w_data_psum = d;
    m_psum[a]  = acc ? model_acc(m_psum[a], d, 1'b1) : d;
    m_psumw[a] = acc ? model_acc(m_psumw[a], d, 1'b0) : d;
    cyc();
    bus.write_en_psum = 1'b0;  bus.acc_en_psum = 1'b0;
    busw.write_en_psum = 1'b0; busw.acc_en_psum = 1'b0;
  endtask

  task automatic rd_both(input int a);
    bus.read_req_psum = 1'b1;  bus.r_addr_psum = AW'(a);
    busw.read_req_psum = 1'b1; busw.r_addr_psum = AW'(a);
    sb.push_back('{2, cyc_n + 1, 64'(m_psum[a])});
    sb.push_back('{4, cyc_n + 1, 64'(m_psumw[a])});
    cyc();
    bus.read_req_psum = 1'b0; busw.read_req_psum = 1'b0;
  endtask

  function automatic logic [63:0] lanes3(input int a0, input int a1, input int a2);
    return 64'({m_psum[a2], m_psum[a1], m_psum[a0]});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc_n = 0;
    reset = 1'b0;
    clear_all();
    cyc(); cyc();
    chk("rst_r_data_iact", 64'(bus.r_data_iact), 64'd0);
    chk("rst_r_data_wght", 64'(bus.r_data_wght), 64'd0);
    chk("rst_r_data_psum", 64'(bus.r_data_psum), 64'd0);
    chk("rst_r_data_inter", 64'(bus.r_data_psum_inter), 64'd0);
    chk("rst_inter_busy", 64'(bus.inter_busy), 64'd0);
    reset = 1'b1;
    cyc();

    // iact / wght basic write then read, latency 1
    wr_iact(5, 16'h1234);
    rd_iact(5);
    wr_wght(5, 16'hBEEF);
    rd_wght(5);
    // same-cycle read and write of one address returns the old word
    bus.write_en_iact = 1'b1; bus.w_addr_iact = AW'(5); bus.w_data_iact = 16'h5555;
    bus.read_req_iact = 1'b1; bus.r_addr_iact = AW'(5);
    sb.push_back('{0, cyc_n + 1, 64'(m_iact[5])});
    m_iact[5] = 16'h5555;
    cyc();
    bus.write_en_iact = 1'b0; bus.read_req_iact = 1'b0;
    rd_iact(5);
    for (int i = 0; i < 4; i++) begin
      wr_iact(100 + i, 16'($urandom));
      wr_wght(200 + i, 16'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      rd_iact(100 + i);
      rd_wght(200 + i);
    end

    // psum accumulate chain: 10 + 4*3 = 22
    wr_psum(7, 16'd10, 1'b0);
    for (int i = 0; i < 4; i++) wr_psum(7, 16'd3, 1'b1);
    rd_psum(7);
    // forwarding from stage 0 (read right after write) and from stage 1 (one gap)
    wr_psum(20, 16'd5, 1'b0);
    rd_psum(20);
    wr_psum(21, 16'd6, 1'b0);
    cyc();
    rd_psum(21);
    // a read does not see a write issued in the same cycle
    bus.write_en_psum = 1'b1; bus.w_addr_psum = AW'(7); bus.w_data_psum = 16'd100;
    bus.read_req_psum = 1'b1; bus.r_addr_psum = AW'(7);
    sb.push_back('{2, cyc_n + 1, 64'(m_psum[7])});
    m_psum[7] = 16'd100;
    cyc();
    bus.write_en_psum = 1'b0; bus.read_req_psum = 1'b0;
    rd_psum(7);

    // overflow: saturating vs wrapping instance, both directions
    wr_both(0, 16'h7FF0, 1'b0);
    wr_both(0, 16'h0100, 1'b1);
    rd_both(0);
    wr_both(2, 16'h8010, 1'b0);
    wr_both(2, 16'hFF00, 1'b1);
    rd_both(2);

    // burst base 1, no stalls; burst request right behind the last write
    wr_psum(1, 16'd11, 1'b0);
    wr_psum(2, 16'd22, 1'b0);
    wr_psum(3, 16'd33, 1'b0);
    bus.read_req_psum_inter = 1'b1; bus.r_addr_psum_inter = AW'(1);
    sb.push_back('{3, cyc_n + 4, lanes3(1, 2, 3)});
    cyc();
    bus.read_req_psum_inter = 1'b0;
    chk("busy_c1", 64'(bus.inter_busy), 64'd1);
    cyc();
    chk("busy_c2", 64'(bus.inter_busy), 64'd1);
    bus.read_req_psum_inter = 1'b1; bus.r_addr_psum_inter = AW'(50);
    cyc();
    bus.read_req_psum_inter = 1'b0;
    chk("busy_c3", 64'(bus.inter_busy), 64'd1);
    cyc();
    chk("busy_done", 64'(bus.inter_busy), 64'd0);
    cyc();
    chk("busy_after", 64'(bus.inter_busy), 64'd0);
    cyc();

    // burst at the last address wraps to 0,1; two local reads stall it
    wr_psum(1023, 16'h0AAA, 1'b0);
    wr_psum(0, 16'h0BBB, 1'b0);
    wr_psum(1, 16'h0CCC, 1'b0);
    bus.read_req_psum_inter = 1'b1; bus.r_addr_psum_inter = AW'(1023);
    sb.push_back('{3, cyc_n + 6, lanes3(1023, 0, 1)});
    cyc();
    bus.read_req_psum_inter = 1'b0;
    cyc();
    rd_psum(2);
    rd_psum(7);
    chk("wrap_busy_c4", 64'(bus.inter_busy), 64'd1);
    cyc();
    chk("wrap_busy_c5", 64'(bus.inter_busy), 64'd1);
    cyc();
    chk("wrap_busy_done", 64'(bus.inter_busy), 64'd0);
    cyc();

    // reset in the middle of a burst: immediate clear, no pulse
    bus.read_req_psum_inter = 1'b1; bus.r_addr_psum_inter = AW'(1);
    cyc();
    bus.read_req_psum_inter = 1'b0;
    cyc();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.inter_busy), 64'd0);
    chk("abort_read_en", 64'(bus.read_en_psum_inter), 64'd0);
    chk("abort_r_data_inter", 64'(bus.r_data_psum_inter), 64'd0);
    chk("abort_r_data_psum", 64'(bus.r_data_psum), 64'd0);
    chk("abort_r_data_iact", 64'(bus.r_data_iact), 64'd0);
    cyc(); cyc();
    reset = 1'b1;
    cyc(); cyc(); cyc();
    // fresh burst after reset; memory contents survive
    bus.read_req_psum_inter = 1'b1; bus.r_addr_psum_inter = AW'(1);
    sb.push_back('{3, cyc_n + 4, lanes3(1, 2, 3)});
    cyc();
    bus.read_req_psum_inter = 1'b0;
    repeat (5) cyc();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
